// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU nibble sequencer.
//   seq_state_t  : sequencer FSM states (IDLE / RUN / DONE)
//   NIBBLE_W     : width of one ALU slice (4 bits)
//   MINUS_S0..5  : slice select codes whose arithmetic carry-out is reported
//                  complemented by the slice
//   is_minus_op  : 1 when a select code is one of those MINUS codes
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [3:0] MINUS_S0 = 4'b0000;
    localparam logic [3:0] MINUS_S1 = 4'b0010;
    localparam logic [3:0] MINUS_S2 = 4'b0011;
    localparam logic [3:0] MINUS_S3 = 4'b0110;
    localparam logic [3:0] MINUS_S4 = 4'b0111;
    localparam logic [3:0] MINUS_S5 = 4'b1011;

    function automatic logic is_minus_op(input logic [3:0] s);
        logic r;
        r = 1'b0;
        case (s)
            MINUS_S0, MINUS_S1, MINUS_S2,
            MINUS_S3, MINUS_S4, MINUS_S5: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Accepts one WIDTH-bit 74181-style operation through a valid/ready
//   handshake, issues it to an external combinational 4-bit ALU slice one
//   nibble per cycle (LSB nibble first), chains the true carry between
//   nibbles and returns the assembled result through a second handshake.
//
// Parameters
//   WIDTH       operand width, multiple of 4, >= 4
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         request handshake
//   op_a, op_b, op_s, op_m,   request operands, select, mode (1 = logic),
//   op_cin                    carry-in to nibble 0
//   alu_a, alu_b, alu_cin     current nibble and carry to the slice (0 outside RUN)
//   alu_s, alu_m              latched select/mode
//   alu_f, alu_c_out,         slice result, slice carry-out (slice convention),
//   alu_a_eq_b                slice A=B
//   out_valid/out_ready       result handshake
//   res_f, res_cout, res_eq   result, final slice carry-out, AND of A=B flags
//   res_zero                  (only with ALU_SEQ_ZERO_FLAG_EN) res_f == 0
//   busy                      FSM not in IDLE
//
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic             alu_c_out,
    input  logic             alu_a_eq_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_cout,
    output logic             res_eq,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             res_zero,
`endif
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    seq_state_t state, state_next;

    logic [NIB-1:0][NIBBLE_W-1:0] a_reg, b_reg, res_reg, res_merged;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             carry, carry_next;
    logic             eq;
    logic             cout_reg;
    logic [IDX_W-1:0] idx;
    logic             accept, run, last;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             zero_reg;
`endif

    assign run    = (state == RUN);
    assign last   = (idx == LAST_IDX);
    assign accept = in_valid & in_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Result with the current slice nibble merged in; used both for the
    // register update and for the zero flag on the final nibble.
    always_comb begin
        res_merged      = res_reg;
        res_merged[idx] = alu_f;
    end

    // The slice reports a complemented carry on MINUS selects; undo it so the
    // true carry chains into the next nibble. Logic mode carries nothing.
    always_comb begin
        carry_next = 1'b0;
        if (!m_reg) carry_next = alu_c_out ^ is_minus_op(s_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            m_reg    <= 1'b0;
            carry    <= 1'b0;
            eq       <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
            res_reg  <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_reg <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        s_reg    <= op_s;
                        m_reg    <= op_m;
                        carry    <= op_cin & ~op_m;
                        idx      <= '0;
                        eq       <= 1'b1;
                        res_reg  <= '0;
                        cout_reg <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_reg <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    res_reg <= res_merged;
                    eq      <= eq & alu_a_eq_b;
                    carry   <= carry_next;
                    if (last) begin
                        cout_reg <= alu_c_out;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_reg <= (res_merged == '0);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // in_ready is held low while reset is asserted even though state is IDLE.
    assign in_ready  = (state == IDLE) & ~rst;
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    assign alu_a   = run ? a_reg[idx] : '0;
    assign alu_b   = run ? b_reg[idx] : '0;
    assign alu_cin = run ? carry : 1'b0;
    assign alu_s   = s_reg;
    assign alu_m   = m_reg;

    assign res_f    = res_reg;
    assign res_cout = cout_reg;
    assign res_eq   = eq;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero = zero_reg;
`endif

endmodule
